// File: rtl/mat_pkg.sv
// Shared widths and state encoding for the matrix-multiply scheduler.
// Operand/product layout: row-major real block (low bits) then imaginary block, 64-bit doubles.
package mat_pkg;

  localparam int DW = 64;

  function automatic int a_w(input int out_row, input int common);
    return 2 * DW * out_row * common;
  endfunction

  function automatic int b_w(input int common, input int out_col);
    return 2 * DW * common * out_col;
  endfunction

  function automatic int p_w(input int out_row, input int out_col);
    return 2 * DW * out_row * out_col;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_VALID,
    S_START,
    S_WAIT,
    S_RESP,
    S_RECOV
  } sched_state_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational one-hot round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx,
  output logic               any
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/mat_mult_sched.sv
// Round-robin scheduler sharing one complex matrix-multiply engine among NUM_REQ requesters.
// gnt is decoded from req while idle so a grant lands in the same cycle the request is seen.
module mat_mult_sched
  import mat_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OUT_ROW = 2,
  parameter int OUT_COL = 3,
  parameter int COMMON  = 2,
  parameter int TIMEOUT = 1024,
  localparam int A_W = a_w(OUT_ROW, COMMON),
  localparam int B_W = b_w(COMMON, OUT_COL),
  localparam int P_W = p_w(OUT_ROW, OUT_COL),
  localparam int PW  = $clog2(NUM_REQ),
  localparam int CW  = $clog2(TIMEOUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [P_W-1:0]         rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [A_W-1:0]         mm_a,
  output logic [B_W-1:0]         mm_b,
  output logic                   mm_valid,
  output logic                   mm_start,
  output logic                   mm_rst,
  input  logic [P_W-1:0]         mm_out,
  input  logic                   mm_done
);

  sched_state_t      state, state_nxt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     owner;
  logic [CW-1:0]     cnt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;
  logic              wd_expired;

  rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign wd_expired = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    rsp_valid = '0;
    mm_valid  = 1'b0;
    mm_start  = 1'b0;
    mm_rst    = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (arb_any) begin
          gnt       = arb_gnt;
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        mm_valid  = 1'b1;
        state_nxt = S_START;
      end
      S_START: begin
        mm_valid  = 1'b1;
        mm_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        mm_start = 1'b1;
        if (mm_done)         state_nxt = S_RESP;
        else if (wd_expired) state_nxt = S_RECOV;
      end
      S_RECOV: begin
        mm_rst    = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand, owner, watchdog and result registers; done is honoured only in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      mm_a     <= '0;
      mm_b     <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            mm_a  <= req_a[int'(arb_idx)*A_W +: A_W];
            mm_b  <= req_b[int'(arb_idx)*B_W +: B_W];
            owner <= arb_idx;
            ptr   <= (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + PW'(1);
          end
        end
        S_START: cnt <= '0;
        S_WAIT: begin
          if (mm_done) begin
            rsp_data <= mm_out;
            rsp_err  <= 1'b0;
          end else if (wd_expired) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_sched.sv
// Bench for mat_mult_sched with a behavioural complex-matmul engine and round-robin reference.
module tb_mat_mult_sched;

  localparam int NR  = 4;
  localparam int R   = 2;
  localparam int M   = 2;
  localparam int C   = 2;
  localparam int TO  = 8;
  localparam int A_W = 128 * R * M;
  localparam int B_W = 128 * M * C;
  localparam int P_W = 128 * R * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     rsp_ready = '0;
  logic [NR*A_W-1:0] req_a = '0;
  logic [NR*B_W-1:0] req_b = '0;
  logic [NR-1:0]     gnt, rsp_valid;
  logic [P_W-1:0]    rsp_data;
  logic              rsp_err, busy, mm_valid, mm_start, mm_rst, mm_done;
  logic [A_W-1:0]    mm_a;
  logic [B_W-1:0]    mm_b;
  logic [P_W-1:0]    mm_out;

  int vectors = 0;
  int miscompares = 0;

  mat_mult_sched #(
    .NUM_REQ(NR), .OUT_ROW(R), .OUT_COL(C), .COMMON(M), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mm_a(mm_a), .mm_b(mm_b), .mm_valid(mm_valid), .mm_start(mm_start),
    .mm_rst(mm_rst), .mm_out(mm_out), .mm_done(mm_done)
  );

  // Complex product on doubles straight from the matrix definition.
  function automatic logic [P_W-1:0] ref_mm(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    logic [P_W-1:0] p;
    real ar, ai, br, bi, sr, si;
    p = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        sr = 0.0; si = 0.0;
        for (int k = 0; k < M; k++) begin
          ar = $bitstoreal(a[64*(i*M+k) +: 64]);
          ai = $bitstoreal(a[64*(R*M+i*M+k) +: 64]);
          br = $bitstoreal(b[64*(k*C+j) +: 64]);
          bi = $bitstoreal(b[64*(M*C+k*C+j) +: 64]);
          sr = sr + ar*br - ai*bi;
          si = si + ar*bi + ai*br;
        end
        p[64*(i*C+j) +: 64]     = $realtobits(sr);
        p[64*(R*C+i*C+j) +: 64] = $realtobits(si);
      end
    return p;
  endfunction

  function automatic logic [A_W-1:0] rnd_mat();
    logic [A_W-1:0] v;
    for (int e = 0; e < A_W/64; e++)
      v[64*e +: 64] = $realtobits(real'(int'($urandom_range(0, 16)) - 8));
    return v;
  endfunction

  function automatic int pick(input logic [NR-1:0] p, input int ptr);
    for (int i = 0; i < NR; i++)
      if (p[(ptr+i)%NR]) return (ptr+i)%NR;
    return -1;
  endfunction

  // Engine model: done arrives eng_lat cycles into WAIT, carrying the product of mm_a/mm_b.
  logic           eng_en = 1'b1;
  int             eng_lat = 5;
  int             eng_cnt = 0;
  logic           eng_done = 1'b0;
  logic [P_W-1:0] eng_out = '0;
  logic           spur_done = 1'b0;
  logic [P_W-1:0] spur_out = '0;

  assign mm_done = eng_done | spur_done;
  assign mm_out  = spur_done ? spur_out : eng_out;

  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (rst || mm_rst) eng_cnt <= 0;
    else if (eng_en && mm_valid && mm_start) eng_cnt <= eng_lat;
    else if (eng_cnt == 1) begin
      eng_cnt  <= 0;
      eng_done <= 1'b1;
      eng_out  <= ref_mm(mm_a, mm_b);
    end else if (eng_cnt > 1) eng_cnt <= eng_cnt - 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic apply_reset();
    rst = 1'b1; req = '0; rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input int r, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                       output logic [NR-1:0] g);
    req_a[r*A_W +: A_W] = a;
    req_b[r*B_W +: B_W] = b;
    req[r] = 1'b1;
    #1 g = gnt;
    @(negedge clk);
    if (g[r]) req[r] = 1'b0;
  endtask

  task automatic wait_gnt(input int limit, output logic [NR-1:0] g);
    int n;
    n = 0;
    #1 g = gnt;
    while (g == '0 && n < limit) begin
      @(negedge clk); #1 g = gnt; n++;
    end
  endtask

  task automatic wait_rsp(input int r, input int n0, input int limit, output int n, output logic seen);
    n = n0;
    seen = rsp_valid[r];
    while (!seen && n < limit) begin
      @(negedge clk); n++; seen = rsp_valid[r];
    end
  endtask

  task automatic release_rsp(input int r);
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    rsp_ready[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({gnt, rsp_valid, rsp_err, busy, mm_valid, mm_start, mm_rst} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl got gnt=%b rsp_valid=%b err=%b busy=%b v/s/r=%b%b%b want all 0",
               gnt, rsp_valid, rsp_err, busy, mm_valid, mm_start, mm_rst);
    end
    vectors++;
    if (rsp_data !== '0 || mm_a !== '0 || mm_b !== '0) begin
      miscompares++;
      $display("FAIL reset_data got rsp_data=%h mm_a=%h want 0", rsp_data, mm_a);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || gnt !== '0) begin
      miscompares++;
      $display("FAIL reset_idle got busy=%b gnt=%b want 0", busy, gnt);
    end
  endtask

  task automatic test_single();
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [NR-1:0]  g;
    int n;
    logic seen;
    a = '0; b = '0;
    a[0 +: 64] = $realtobits(1.0);  a[64 +: 64]  = $realtobits(2.0);
    a[128 +: 64] = $realtobits(3.0); a[192 +: 64] = $realtobits(4.0);
    b[0 +: 64] = $realtobits(1.0);  b[192 +: 64] = $realtobits(1.0);
    eng_lat = 5;
    issue(1, a, b, g);
    vectors++;
    if (g !== 4'b0010) begin miscompares++; $display("FAIL single_gnt got %b want 0010", g); end
    vectors++;
    if (mm_valid !== 1'b1 || mm_start !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_valid_phase got valid=%b start=%b busy=%b want 1 0 1", mm_valid, mm_start, busy);
    end
    @(negedge clk);
    vectors++;
    if (mm_valid !== 1'b1 || mm_start !== 1'b1 || mm_a !== a || mm_b !== b) begin
      miscompares++;
      $display("FAIL single_start_phase got valid=%b start=%b operands_ok=%b want 1 1 1",
               mm_valid, mm_start, (mm_a === a && mm_b === b));
    end
    wait_rsp(1, 2, 40, n, seen);
    vectors++;
    if (!seen || n !== 9) begin miscompares++; $display("FAIL single_latency got %0d (seen=%b) want 9", n, seen); end
    vectors++;
    if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_rsp got valid=%b err=%b want 0010 0", rsp_valid, rsp_err);
    end
    vectors++;
    if (rsp_data !== a) begin miscompares++; $display("FAIL single_data got %h want %h", rsp_data, a); end
    release_rsp(1);
  endtask

  task automatic test_rst_mid();
    logic [NR-1:0] g;
    int hits;
    eng_lat = 7;
    issue(2, rnd_mat(), rnd_mat(), g);
    repeat (3) @(negedge clk);
    vectors++;
    if (mm_start !== 1'b1 || mm_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_wait got start=%b valid=%b want 1 0", mm_start, mm_valid);
    end
    rst = 1'b1; req = '0;
    @(negedge clk);
    vectors++;
    if ({gnt, rsp_valid, rsp_err, busy, mm_valid, mm_start, mm_rst} !== '0 ||
        rsp_data !== '0 || mm_a !== '0 || mm_b !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs got busy=%b start=%b data_zero=%b mm_a_zero=%b want 0 0 1 1",
               busy, mm_start, rsp_data === '0, mm_a === '0);
    end
    rst = 1'b0;
    hits = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid !== '0 || busy !== 1'b0) hits++; end
    vectors++;
    if (hits !== 0) begin miscompares++; $display("FAIL rst_mid_dropped got %0d active cycles want 0", hits); end
  endtask

  task automatic test_all_four();
    logic [A_W-1:0] ta [NR];
    logic [B_W-1:0] tb_ [NR];
    logic [NR-1:0] g, pending;
    int m_ptr, exp_w, n;
    logic seen;
    apply_reset();
    m_ptr = 0; pending = '1; eng_lat = 3; rsp_ready = '1;
    for (int k = 0; k < NR; k++) begin
      ta[k] = rnd_mat(); tb_[k] = rnd_mat();
      req_a[k*A_W +: A_W] = ta[k]; req_b[k*B_W +: B_W] = tb_[k];
    end
    req = '1;
    for (int j = 0; j < NR; j++) begin
      wait_gnt(20, g);
      exp_w = pick(pending, m_ptr);
      vectors++;
      if (g !== (4'b0001 << exp_w)) begin miscompares++; $display("FAIL rr_order job %0d got %b want requester %0d", j, g, exp_w); end
      m_ptr = (exp_w + 1) % NR; pending[exp_w] = 1'b0;
      @(negedge clk); req[exp_w] = 1'b0;
      wait_rsp(exp_w, 1, 30, n, seen);
      vectors++;
      if (!seen || rsp_data !== ref_mm(ta[exp_w], tb_[exp_w]) || rsp_err !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_data job %0d seen=%b err=%b got %h", j, seen, rsp_err, rsp_data);
      end
      @(negedge clk);
    end
    req_a[2*A_W +: A_W] = rnd_mat(); req_b[2*B_W +: B_W] = rnd_mat();
    req = 4'b0100;
    wait_gnt(20, g);
    vectors++;
    if (g !== 4'b0100) begin miscompares++; $display("FAIL rr_single_after got %b want 0100", g); end
    @(negedge clk); req = '0;
    wait_rsp(2, 1, 30, n, seen);
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [NR-1:0] g;
    logic [P_W-1:0] d0;
    int n;
    logic seen;
    a = rnd_mat(); b = rnd_mat(); eng_lat = 2;
    issue(0, a, b, g);
    req_a[3*A_W +: A_W] = rnd_mat(); req_b[3*B_W +: B_W] = rnd_mat();
    req[3] = 1'b1;
    wait_rsp(0, 1, 30, n, seen);
    d0 = rsp_data;
    vectors++;
    if (!seen || d0 !== ref_mm(a, b)) begin miscompares++; $display("FAIL bp_data seen=%b got %h", seen, d0); end
    rsp_ready[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (rsp_valid !== 4'b0001 || rsp_data !== d0 || gnt !== '0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got valid=%b gnt=%b busy=%b stable=%b want 0001 0000 1 1",
                 i, rsp_valid, gnt, busy, rsp_data === d0);
      end
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    vectors++;
    if (gnt !== 4'b1000) begin miscompares++; $display("FAIL b2b_gnt got %b want 1000", gnt); end
    @(negedge clk); req[3] = 1'b0;
    wait_rsp(3, 1, 30, n, seen);
    release_rsp(3);
  endtask

  task automatic test_timeout();
    logic [NR-1:0] g;
    logic [P_W-1:0] d;
    logic e;
    int c, rst_at, rst_n, rsp_at;
    eng_en = 1'b0;
    issue(1, rnd_mat(), rnd_mat(), g);
    c = 1; rst_at = -1; rst_n = 0; rsp_at = -1; e = 1'b0; d = '1;
    while (rsp_at < 0 && c <= 20) begin
      if (mm_rst) begin rst_n++; if (rst_at < 0) rst_at = c; end
      if (rsp_valid[1]) begin rsp_at = c; e = rsp_err; d = rsp_data; end
      else begin @(negedge clk); c++; end
    end
    vectors++;
    if (rst_at !== 11 || rst_n !== 1) begin miscompares++; $display("FAIL to_mm_rst got cycle %0d count %0d want 11 1", rst_at, rst_n); end
    vectors++;
    if (rsp_at !== 12) begin miscompares++; $display("FAIL to_rsp_cycle got %0d want 12", rsp_at); end
    vectors++;
    if (e !== 1'b1 || d !== '0) begin miscompares++; $display("FAIL to_err_data got err=%b data=%h want 1 0", e, d); end
    release_rsp(1);
    eng_en = 1'b1;
  endtask

  task automatic test_spurious();
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [NR-1:0] g;
    logic [P_W-1:0] d;
    int n;
    logic seen;
    spur_out = {8{$urandom(), $urandom()}} | 1;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (rsp_data !== '0 || rsp_err !== 1'b1 || busy !== 1'b0 || rsp_valid !== '0) begin
      miscompares++;
      $display("FAIL spur_idle got err=%b busy=%b valid=%b data_zero=%b want 1 0 0000 1",
               rsp_err, busy, rsp_valid, rsp_data === '0);
    end
    a = rnd_mat(); b = rnd_mat(); eng_lat = 3;
    issue(2, a, b, g);
    wait_rsp(2, 1, 30, n, seen);
    d = rsp_data;
    vectors++;
    if (!seen || d !== ref_mm(a, b) || rsp_err !== 1'b0) begin miscompares++; $display("FAIL spur_job seen=%b err=%b got %h", seen, rsp_err, d); end
    spur_out = ~d;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (rsp_data !== d || rsp_valid !== 4'b0100 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL spur_resp got valid=%b busy=%b stable=%b want 0100 1 1", rsp_valid, busy, rsp_data === d);
    end
    release_rsp(2);
  endtask

  task automatic test_random();
    logic [A_W-1:0] ta [NR];
    logic [B_W-1:0] tb_ [NR];
    logic [NR-1:0] g, pending, fresh;
    int m_ptr, exp_w, n;
    logic seen;
    apply_reset();
    m_ptr = 0; pending = '0;
    for (int j = 0; j < 40; j++) begin
      fresh = NR'($urandom_range(1, 15)) & ~pending;
      for (int k = 0; k < NR; k++)
        if (fresh[k]) begin
          ta[k] = rnd_mat(); tb_[k] = rnd_mat();
          req_a[k*A_W +: A_W] = ta[k]; req_b[k*B_W +: B_W] = tb_[k];
        end
      pending = pending | fresh;
      req = pending;
      eng_lat = $urandom_range(1, 7);
      wait_gnt(5, g);
      exp_w = pick(pending, m_ptr);
      vectors++;
      if (g !== (4'b0001 << exp_w)) begin miscompares++; $display("FAIL rand_gnt job %0d got %b want requester %0d", j, g, exp_w); end
      m_ptr = (exp_w + 1) % NR; pending[exp_w] = 1'b0;
      @(negedge clk); req = pending;
      wait_rsp(exp_w, 1, 40, n, seen);
      vectors++;
      if (!seen || n !== eng_lat + 4 || rsp_data !== ref_mm(ta[exp_w], tb_[exp_w]) || rsp_err !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_rsp job %0d seen=%b latency %0d want %0d err=%b", j, seen, n, eng_lat + 4, rsp_err);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_rsp(exp_w);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rst_mid();
    test_all_four();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
